// File: rtl/bank_port_arbiter.sv
// bank_port_arbiter: shares one single-port BRAM bank between two diffusion
// requesters. Grants are combinational and round-robin under contention.
// Accesses are registered onto the bank port, and read data is routed back
// to the issuing requester with a one-cycle valid pulse.
module bank_port_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int LOWER_ADDR = 0,
  parameter int UPPER_ADDR = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqA,
  input  logic                  weA,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0] wdataA,
  output logic                  gntA,
  output logic                  rvalidA,
  output logic [DATA_WIDTH-1:0] rdataA,
  input  logic                  reqB,
  input  logic                  weB,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] wdataB,
  output logic                  gntB,
  output logic                  rvalidB,
  output logic [DATA_WIDTH-1:0] rdataB,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           conflict_cnt
);

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} lastGnt_t;

  localparam logic [ADDR_WIDTH-1:0] LOWER = ADDR_WIDTH'(LOWER_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(UPPER_ADDR - LOWER_ADDR);

  lastGnt_t lastGnt, lastGntNext;

  // Window test folded into one subtraction: the borrow bit flags addr < LOWER,
  // and the low bits are the bank-local address reused by the command register.
  logic [ADDR_WIDTH:0] diffA, diffB;
  logic                inA, inB, contend, issueRead;

  assign diffA     = {1'b0, addrA} - {1'b0, LOWER};
  assign diffB     = {1'b0, addrB} - {1'b0, LOWER};
  assign inA       = rst_n & reqA & ~diffA[ADDR_WIDTH] & (diffA[ADDR_WIDTH-1:0] <= SPAN);
  assign inB       = rst_n & reqB & ~diffB[ADDR_WIDTH] & (diffB[ADDR_WIDTH-1:0] <= SPAN);
  assign contend   = inA & inB;
  assign issueRead = (gntA & ~weA) | (gntB & ~weB);

  // Arbitration: uncontended requester wins; on contention the one not granted last.
  always_comb begin
    gntA        = 1'b0;
    gntB        = 1'b0;
    lastGntNext = lastGnt;
    if (contend) begin
      if (lastGnt == LAST_B) gntA = 1'b1;
      else                   gntB = 1'b1;
    end else begin
      gntA = inA;
      gntB = inB;
    end
    if (gntA)      lastGntNext = LAST_A;
    else if (gntB) lastGntNext = LAST_B;
  end

  // Last-granted register; reset to B so A wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lastGnt <= LAST_B;
    else        lastGnt <= lastGntNext;
  end

  // Saturating contention counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          conflict_cnt <= '0;
    else if (contend && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 16'd1;
  end

  // Command register driving the bank port; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= gntA | gntB;
      mem_we <= (gntA & weA) | (gntB & weB);
      if (gntA) begin
        mem_addr  <= diffA[ADDR_WIDTH-1:0];
        mem_wdata <= wdataA;
      end else if (gntB) begin
        mem_addr  <= diffB[ADDR_WIDTH-1:0];
        mem_wdata <= wdataB;
      end
    end
  end

  // Read tracking: stage k holds the read granted k+1 cycles ago, so stage
  // RD_LATENCY lines up with mem_rdata for that read.
  logic [RD_LATENCY:0] pipeValid, pipeOwnerB;

  // Shift {valid, owner} of each granted read toward the return point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipeValid  <= '0;
      pipeOwnerB <= '0;
    end else begin
      pipeValid  <= {pipeValid[RD_LATENCY-1:0], issueRead};
      pipeOwnerB <= {pipeOwnerB[RD_LATENCY-1:0], gntB};
    end
  end

  // Capture returning data for its owner and pulse that owner's valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalidA <= 1'b0;
      rvalidB <= 1'b0;
      rdataA  <= '0;
      rdataB  <= '0;
    end else begin
      rvalidA <= 1'b0;
      rvalidB <= 1'b0;
      if (pipeValid[RD_LATENCY]) begin
        if (pipeOwnerB[RD_LATENCY]) begin
          rvalidB <= 1'b1;
          rdataB  <= mem_rdata;
        end else begin
          rvalidA <= 1'b1;
          rdataA  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_bank_port_arbiter.sv
// Testbench for bank_port_arbiter: default-window instance checked against a
// transaction-level reference model, plus an offset-window / latency-3
// instance exercised with hand-written sequences.
module tb_bank_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int LO0 = 0, HI0 = 4, LAT0 = 1;
  localparam int LO1 = 8, HI1 = 12, LAT1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bramInit;
  always #5 clk = ~clk;

  // Instance 0 signals (default parameters)
  logic reqA, weA, reqB, weB, gntA, gntB, rvalidA, rvalidB, memEn, memWe;
  logic [AW-1:0] addrA, addrB, memAddr;
  logic [DW-1:0] wdataA, wdataB, rdataA, rdataB, memWdata, memRdata;
  logic [15:0] conflictCnt;

  // Instance 1 signals (window 8..12, read latency 3)
  logic reqA1, weA1, reqB1, weB1, gntA1, gntB1, rvalidA1, rvalidB1, memEn1, memWe1;
  logic [AW-1:0] addrA1, addrB1, memAddr1;
  logic [DW-1:0] wdataA1, wdataB1, rdataA1, rdataB1, memWdata1, memRdata1;
  logic [15:0] conflictCnt1;

  bank_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOWER_ADDR(LO0),
                      .UPPER_ADDR(HI0), .RD_LATENCY(LAT0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .reqA(reqA), .weA(weA), .addrA(addrA), .wdataA(wdataA),
    .gntA(gntA), .rvalidA(rvalidA), .rdataA(rdataA),
    .reqB(reqB), .weB(weB), .addrB(addrB), .wdataB(wdataB),
    .gntB(gntB), .rvalidB(rvalidB), .rdataB(rdataB),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .conflict_cnt(conflictCnt));

  bank_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOWER_ADDR(LO1),
                      .UPPER_ADDR(HI1), .RD_LATENCY(LAT1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .reqA(reqA1), .weA(weA1), .addrA(addrA1), .wdataA(wdataA1),
    .gntA(gntA1), .rvalidA(rvalidA1), .rdataA(rdataA1),
    .reqB(reqB1), .weB(weB1), .addrB(addrB1), .wdataB(wdataB1),
    .gntB(gntB1), .rvalidB(rvalidB1), .rdataB(rdataB1),
    .mem_en(memEn1), .mem_we(memWe1), .mem_addr(memAddr1), .mem_wdata(memWdata1),
    .mem_rdata(memRdata1), .conflict_cnt(conflictCnt1));

  function automatic logic [DW-1:0] initWord(input int i);
    return (i == 3) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // Bank 0 BRAM: latency 1
  logic [DW-1:0] bram0 [32];
  logic [DW-1:0] rd0;
  always @(posedge clk) begin
    if (bramInit) begin
      for (int i = 0; i < 32; i++) bram0[i] <= initWord(i);
    end else if (memEn) begin
      if (memWe) bram0[memAddr[4:0]] <= memWdata;
      else       rd0 <= bram0[memAddr[4:0]];
    end
  end
  assign memRdata = rd0;

  // Bank 1 BRAM: latency 3
  logic [DW-1:0] bram1 [32];
  logic [DW-1:0] rp1 [3];
  always @(posedge clk) begin
    if (bramInit) begin
      for (int i = 0; i < 32; i++) bram1[i] <= '0;
    end else if (memEn1 && memWe1) begin
      bram1[memAddr1[4:0]] <= memWdata1;
    end
    rp1[0] <= bram1[memAddr1[4:0]];
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign memRdata1 = rp1[2];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for instance 0: expected memory contents, pending returns,
  // and the register values the bank port / return path should show.
  typedef struct {
    int            due;
    bit            ownerB;
    logic [DW-1:0] data;
  } ret_t;
  ret_t retQ[$];
  logic [DW-1:0] mMem [5];
  bit            mLastA;
  int            cyc;
  logic          eMemEn, eMemWe, eRvA, eRvB;
  logic [AW-1:0] eMemAddr;
  logic [DW-1:0] eMemWdata, eRdA, eRdB;
  logic [15:0]   eCnt;
  logic          sGntA, sGntB, sMemEn, sRvA, sRvB;
  logic [AW-1:0] sMemAddr;
  logic [DW-1:0] sRdA;

  task automatic modelReset();
    retQ.delete();
    mLastA = 1'b0;
    eMemEn = 0; eMemWe = 0; eRvA = 0; eRvB = 0;
    eMemAddr = '0; eMemWdata = '0; eRdA = '0; eRdB = '0; eCnt = '0;
  endtask

  function automatic bit inWin0(input logic r, input logic [AW-1:0] a);
    return r && int'(a) >= LO0 && int'(a) <= HI0;
  endfunction

  // One clock cycle on instance 0: drive, check against the model, advance it.
  task automatic step(input logic rA, input logic wA, input logic [AW-1:0] aA, input logic [DW-1:0] dA,
                      input logic rB, input logic wB, input logic [AW-1:0] aB, input logic [DW-1:0] dB);
    bit inA, inB, winA, winB, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    ret_t r;
    @(negedge clk);
    reqA = rA; weA = wA; addrA = aA; wdataA = dA;
    reqB = rB; weB = wB; addrB = aB; wdataB = dB;
    #1;
    chk("mem_en", memEn, eMemEn);
    chk("mem_we", memWe, eMemWe);
    chk("mem_addr", memAddr, eMemAddr);
    chk("mem_wdata", memWdata, eMemWdata);
    chk("conflict_cnt", conflictCnt, eCnt);
    chk("rvalidA", rvalidA, eRvA);
    chk("rdataA", rdataA, eRdA);
    chk("rvalidB", rvalidB, eRvB);
    chk("rdataB", rdataB, eRdB);
    inA = inWin0(rA, aA);
    inB = inWin0(rB, aB);
    if (inA && inB) begin
      winA = !mLastA;
      if (eCnt != 16'hFFFF) eCnt = eCnt + 16'd1;
    end else begin
      winA = inA;
    end
    winB = inB && !winA;
    chk("gntA", gntA, winA);
    chk("gntB", gntB, winB);
    sGntA = gntA; sGntB = gntB; sMemEn = memEn; sMemAddr = memAddr;
    sRvA = rvalidA; sRdA = rdataA; sRvB = rvalidB;
    if (winA || winB) begin
      w = winA ? wA : wB;
      a = winA ? aA : aB;
      d = winA ? dA : dB;
      eMemEn = 1; eMemWe = w; eMemAddr = AW'(int'(a) - LO0); eMemWdata = d;
      if (w) mMem[int'(a) - LO0] = d;
      else   retQ.push_back('{cyc + 2 + LAT0, winB, mMem[int'(a) - LO0]});
      mLastA = winA;
    end else begin
      eMemEn = 0; eMemWe = 0;
    end
    eRvA = 0; eRvB = 0;
    if (retQ.size() > 0 && retQ[0].due == cyc + 1) begin
      r = retQ.pop_front();
      if (r.ownerB) begin eRvB = 1; eRdB = r.data; end
      else          begin eRvA = 1; eRdA = r.data; end
    end
    cyc++;
  endtask

  task automatic idle0(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic chkZero0(input string tag);
    chk({tag, " gntA"}, gntA, 0);       chk({tag, " gntB"}, gntB, 0);
    chk({tag, " mem_en"}, memEn, 0);    chk({tag, " mem_we"}, memWe, 0);
    chk({tag, " mem_addr"}, memAddr, 0); chk({tag, " mem_wdata"}, memWdata, 0);
    chk({tag, " rvalidA"}, rvalidA, 0); chk({tag, " rdataA"}, rdataA, 0);
    chk({tag, " rvalidB"}, rvalidB, 0); chk({tag, " rdataB"}, rdataB, 0);
    chk({tag, " conflict_cnt"}, conflictCnt, 0);
  endtask

  function automatic logic [AW-1:0] rndAddr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0)      return 13'h1FFF;
    else if (k < 3)  return AW'($urandom_range(5, 7));
    else             return AW'($urandom_range(0, 4));
  endfunction

  typedef struct {
    logic          rA;
    logic [AW-1:0] aA;
    logic          rB;
    logic [AW-1:0] aB;
    logic          eA;
    logic          eB;
  } vec_t;
  vec_t tbl[10];

  initial begin
    logic [5:0] gPat, rPat;
    int gN, rN;
    logic hA, hwA, hB, hwB;
    logic [AW-1:0] haA, haB;
    logic [DW-1:0] hdA, hdB;

    reqA = 0; weA = 0; addrA = '0; wdataA = '0; reqB = 0; weB = 0; addrB = '0; wdataB = '0;
    reqA1 = 0; weA1 = 0; addrA1 = '0; wdataA1 = '0; reqB1 = 0; weB1 = 0; addrB1 = '0; wdataB1 = '0;
    bramInit = 1;
    cyc = 0;
    modelReset();
    for (int i = 0; i < 5; i++) mMem[i] = initWord(i);

    // Reset state
    #23;
    chkZero0("reset");
    chk("reset u1 mem_en", memEn1, 0);
    chk("reset u1 mem_addr", memAddr1, 0);
    chk("reset u1 rvalidA", rvalidA1, 0);
    chk("reset u1 conflict_cnt", conflictCnt1, 0);
    @(negedge clk);
    rst_n = 1; bramInit = 0;

    // Contention from reset: both read for 6 cycles
    gPat = '0; rPat = '0; gN = 0; rN = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) step(1, 0, 13'd1, '0, 1, 0, 13'd2, '0);
      else       step(0, 0, '0, '0, 0, 0, '0, '0);
      if (sGntA || sGntB) begin gPat = {gPat[4:0], sGntB}; gN++; end
      if (sRvA || sRvB)   begin rPat = {rPat[4:0], sRvB}; rN++; end
      if (i == 6) chk("contention count", conflictCnt, 16'd6);
    end
    chk("contention grant count", gN, 6);
    chk("contention grant order", gPat, 6'b010101);
    chk("contention return count", rN, 6);
    chk("contention return order", rPat, 6'b010101);

    // Single read of word 3
    step(1, 0, 13'd3, '0, 0, 0, '0, '0);
    chk("single gntA", sGntA, 1);
    step(0, 0, '0, '0, 0, 0, '0, '0);
    chk("single mem_en t+1", sMemEn, 1);
    chk("single mem_addr t+1", sMemAddr, 3);
    chk("single rvalidB t+1", sRvB, 0);
    step(0, 0, '0, '0, 0, 0, '0, '0);
    chk("single rvalidA t+2", sRvA, 0);
    step(0, 0, '0, '0, 0, 0, '0, '0);
    chk("single rvalidA t+3", sRvA, 1);
    chk("single rdataA t+3", sRdA, 32'hDEADBEEF);
    chk("single rvalidB t+3", sRvB, 0);

    // Grant table (gaps and out-of-window addresses included)
    tbl[0] = '{1'b1, 13'd3,    1'b0, 13'd0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 13'd0,    1'b1, 13'd4, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 13'd5,    1'b1, 13'd2, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 13'd1,    1'b1, 13'd1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 13'd2,    1'b1, 13'd2, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 13'd4,    1'b1, 13'd5, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 13'd2,    1'b0, 13'd3, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 13'd2,    1'b1, 13'd3, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 13'h1FFF, 1'b1, 13'd4, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 13'd0,    1'b1, 13'd0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rA, 1'(i % 2), tbl[i].aA, 32'hC0DE_0000 + 32'(i),
           tbl[i].rB, 0, tbl[i].aB, 32'hB0B0_0000 + 32'(i));
      chk($sformatf("table[%0d] gntA", i), sGntA, tbl[i].eA);
      chk($sformatf("table[%0d] gntB", i), sGntB, tbl[i].eB);
    end
    idle0(4);

    // Random traffic; an in-window request is held until granted
    hA = 0; hB = 0; hwA = 0; hwB = 0; haA = '0; haB = '0; hdA = '0; hdB = '0;
    sGntA = 0; sGntB = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!(hA && !sGntA && inWin0(hA, haA))) begin
        hA = ($urandom_range(0, 9) < 7); hwA = 1'($urandom_range(0, 1));
        haA = rndAddr(); hdA = $urandom;
      end
      if (!(hB && !sGntB && inWin0(hB, haB))) begin
        hB = ($urandom_range(0, 9) < 7); hwB = 1'($urandom_range(0, 1));
        haB = rndAddr(); hdB = $urandom;
      end
      step(hA, hwA, haA, hdA, hB, hwB, haB, hdB);
    end
    idle0(6);

    // Instance 1: B writes global 8..12, which must map to bank words 0..4
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      reqB1 = (i < 5); weB1 = 1; addrB1 = AW'(8 + i); wdataB1 = 32'hA5A5_0000 + 32'(i);
      #1;
      if (i < 5) chk($sformatf("win gntB %0d", i), gntB1, 1);
      if (i > 0) begin
        chk($sformatf("win mem_en %0d", i), memEn1, 1);
        chk($sformatf("win mem_we %0d", i), memWe1, 1);
        chk($sformatf("win mem_addr %0d", i), memAddr1, i - 1);
        chk($sformatf("win mem_wdata %0d", i), memWdata1, 32'hA5A5_0000 + 32'(i - 1));
      end
    end
    // A just outside both edges of the window
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reqB1 = 0; reqA1 = (i < 2); weA1 = 0; addrA1 = (i == 0) ? 13'd7 : 13'd13;
      #1;
      chk($sformatf("outwin gntA %0d", i), gntA1, 0);
      chk($sformatf("outwin mem_en %0d", i), memEn1, 0);
    end
    // Back-to-back reads of bank words 0,1,2 at read latency 3
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      reqA1 = (k < 3); weA1 = 0; addrA1 = AW'(8 + k);
      #1;
      if (k < 3) chk($sformatf("lat3 gntA %0d", k), gntA1, 1);
      chk($sformatf("lat3 rvalidA k=%0d", k), rvalidA1, (k >= 5 && k <= 7));
      if (k >= 5 && k <= 7) chk($sformatf("lat3 rdataA k=%0d", k), rdataA1, 32'hA5A5_0000 + 32'(k - 5));
      chk($sformatf("lat3 rvalidB k=%0d", k), rvalidB1, 0);
    end
    reqA1 = 0;

    // Reset while a read from A is in flight
    step(1, 0, 13'd3, '0, 0, 0, '0, '0);
    chk("rst read gntA", sGntA, 1);
    @(posedge clk);
    #2;
    chk("rst mem_en before", memEn, 1);
    rst_n = 0;
    #1;
    chkZero0("async reset");
    reqA = 0;
    @(negedge clk);
    rst_n = 1;
    modelReset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0, '0, 0, 0, '0, '0);
      chk($sformatf("post-reset rvalidA %0d", i), sRvA, 0);
    end
    step(1, 0, 13'd2, '0, 1, 0, 13'd4, '0);
    chk("post-reset contention gntA", sGntA, 1);
    chk("post-reset contention gntB", sGntB, 0);

    // Saturation: 70000 contention cycles
    for (int n = 0; n < 70000; n++) step(1, 0, 13'd0, '0, 1, 0, 13'd1, '0);
    idle0(1);
    chk("saturated conflict_cnt", conflictCnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bank_port_arbiter.md
# bank_port_arbiter

Registered request/grant arbiter that shares one single-port BRAM bank, mapped to the address window [LOWER_ADDR, UPPER_ADDR], between two diffusion requesters A and B. It sits between the diffusion compute modules and one bank of the partitioned score/residual memory. It issues at most one bank access per cycle, grants contending requesters in round-robin order, and translates global addresses to bank-local ones. It returns read data with a per-requester valid pulse and counts contention cycles.

## Interface
Parameters:
- ADDR_WIDTH, 13, global and bank address width
- DATA_WIDTH, 32, data word width
- LOWER_ADDR, 0, first global address owned by this bank (inclusive)
- UPPER_ADDR, 4, last global address owned by this bank (inclusive)
- RD_LATENCY, 1, BRAM read latency in cycles (legal 1..4)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reqA  in  1  requester A access request; held until gntA
- weA  in  1  A: 1 = write, 0 = read
- addrA  in  ADDR_WIDTH  A global address
- wdataA  in  DATA_WIDTH  A write data
- gntA  out  1  A request accepted this cycle
- rvalidA  out  1  rdataA valid (one-cycle pulse per read)
- rdataA  out  DATA_WIDTH  A read data
- reqB, weB, addrB, wdataB, gntB, rvalidB, rdataB  same as A, for requester B
- mem_en  out  1  bank access strobe
- mem_we  out  1  bank write enable
- mem_addr  out  ADDR_WIDTH  bank-local address, addr − LOWER_ADDR
- mem_wdata  out  DATA_WIDTH  bank write data
- mem_rdata  in  DATA_WIDTH  bank read data, valid RD_LATENCY cycles after the mem_en cycle
- conflict_cnt  out  16  saturating count of contention cycles

## Operation
- In-window: a request is in-window when reqX=1 and LOWER_ADDR ≤ addrX ≤ UPPER_ADDR, compared unsigned. Out-of-window requests are never granted and have no effect.
- Arbitration is combinational within the cycle:
  - Only A in-window: gntA=1.
  - Only B in-window: gntB=1.
  - Both in-window: grant the requester that was not granted last (last_gnt register), and conflict_cnt increments by 1, saturating at 16'hFFFF.
  - gntA and gntB are never both 1.
- last_gnt updates on every grant. Its reset value is B, so A wins the first contention.
- Starvation bound: a contention loser that keeps requesting is granted in the next cycle.
- Command register: on the edge after a grant, it loads mem_en=1, mem_we=weX, mem_addr=addrX−LOWER_ADDR (truncated to ADDR_WIDTH), and mem_wdata=wdataX. In a cycle with no grant it loads mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their values.
- Read tracking:
  - A shift register RD_LATENCY+1 deep carries {valid, owner} for each granted read. Writes do not enter it.
  - When the tagged entry aligns with mem_rdata, rdataX is registered from mem_rdata and rvalidX pulses for 1 cycle.
  - rdataX holds its last value when rvalidX=0.
- Ordering: reads return in grant order. A and B returns never collide, because at most one access is issued per cycle.
- Reset (asynchronous, any time): all outputs go to 0, last_gnt goes to B, and the tracking pipeline is cleared. In-flight reads are discarded and produce no rvalid after reset deasserts.

## Timing
- Grant cycle t: gntX=1 combinationally in cycle t. The requester may change its request inputs from cycle t+1.
- Command: mem_en=1 in cycle t+1.
- Read data: mem_rdata is sampled in cycle t+1+RD_LATENCY. rvalidX=1 with rdataX valid in cycle t+2+RD_LATENCY, which is t+3 at the default RD_LATENCY.
- Write: the memory is updated at the end of cycle t+1.
- Throughput: 1 access per cycle. Back-to-back grants produce back-to-back mem_en and back-to-back rvalid pulses.
- Read-after-write to the same address: a read granted in cycle t+1 after a write granted in cycle t returns the new data. This relies on the BRAM being read-first/write-first coherent across cycles.

## Test plan
- Single read: reqA=1, weA=0, addrA=3, bank word 3 = 32'hDEADBEEF.
  - Expect gntA in cycle t, mem_en=1 and mem_addr=3 in cycle t+1.
  - Expect rvalidA=1, rdataA=32'hDEADBEEF in cycle t+3, and rvalidB=0 throughout.
- Window offset: with LOWER_ADDR=8 and UPPER_ADDR=12, writes from B to addresses 8..12 must appear on mem_addr as 0..4. Requests from A to addresses 7 and 13 get no grant and produce no mem_en.
- Contention: A and B both request in-window and stay asserted for 6 cycles from reset.
  - Expect grants A,B,A,B,A,B.
  - Expect conflict_cnt=6 at the end (the last cycle still counts) and the read returns in the same order.
- Saturation: hold both requests in-window for 70000 cycles. conflict_cnt must stop at 16'hFFFF and not wrap.
- Reset mid-read: grant a read from A, then pulse rst_n low in cycle t+1 before the data returns. Expect:
  - All outputs go to 0 immediately (asynchronously).
  - No rvalidA after release.
  - The next contention is won by A.
- RD_LATENCY=3: back-to-back reads by A to addresses 0,1,2 must give rvalidA pulses in 3 consecutive cycles starting at t+5, carrying the correct data.
